// File: rtl/memory_arbiter_if.sv
// Bundle of per-CU request/bus signals and the muxed memory port of memory_arbiter.
// slave: the arbiter side; master: the CU/memory side driving requests.
interface memory_arbiter_if #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned memory_size_log = 10,
    parameter int unsigned data_width      = 32
);
    logic [NUM_REQ-1:0]                 i_Request;
    logic [NUM_REQ*memory_size_log-1:0] i_Address;
    logic [NUM_REQ-1:0]                 i_Write_Enable;
    logic [NUM_REQ*data_width-1:0]      i_Write_Data;
    logic [NUM_REQ-1:0]                 o_Grant;
    logic [memory_size_log-1:0]         o_Memory_Address;
    logic                               o_Memory_Write_Enable;
    logic [data_width-1:0]              o_Memory_Write_Data;
    logic                               o_Busy;
    logic                               o_Timeout;

    modport slave (
        input  i_Request, i_Address, i_Write_Enable, i_Write_Data,
        output o_Grant, o_Memory_Address, o_Memory_Write_Enable, o_Memory_Write_Data,
        output o_Busy, o_Timeout
    );

    modport master (
        output i_Request, i_Address, i_Write_Enable, i_Write_Data,
        input  o_Grant, o_Memory_Address, o_Memory_Write_Enable, o_Memory_Write_Data,
        input  o_Busy, o_Timeout
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one data memory among NUM_REQ CUs.
// Define ARB_HOLD_TIMEOUT_EN to revoke any grant held for MAX_HOLD cycles.
module memory_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned REQ_LOG         = 2,
    parameter int unsigned memory_size_log = 10,
    parameter int unsigned data_width      = 32,
    parameter int unsigned MAX_HOLD        = 64
) (
    input logic              i_Clock,
    input logic              i_Reset,
    memory_arbiter_if.slave  arb_bus
);
    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [REQ_LOG-1:0]   last_q, last_d;
    logic                 found;
    logic [REQ_LOG-1:0]   win;

    if (NUM_REQ < 2 || (1 << REQ_LOG) < NUM_REQ || MAX_HOLD < 1) begin : g_param_check
        $error("memory_arbiter: inconsistent parameters");
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CntW-1:0] hold_q, hold_d;
    logic            timeout_q, timeout_d;
`endif

    // First requester after the previous winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned        cand;
            logic [REQ_LOG-1:0] idx;
            cand = (32'(last_q) + i) % NUM_REQ;
            idx  = cand[REQ_LOG-1:0];
            if (!found && arb_bus.i_Request[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                    state_d      = StGrant;
`ifdef ARB_HOLD_TIMEOUT_EN
                    hold_d       = '0;
`endif
                end
            end
            StGrant: begin
                // last_q always names the current owner while granted.
                if (!arb_bus.i_Request[last_q]) begin
                    grant_d = '0;
                    state_d = StIdle;
                end
`ifdef ARB_HOLD_TIMEOUT_EN
                else if (hold_q == CntW'(MAX_HOLD - 1)) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= REQ_LOG'(NUM_REQ - 1);
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // One-hot AND-OR mux; an all-zero grant yields an all-zero memory port.
    always_comb begin
        arb_bus.o_Memory_Address      = '0;
        arb_bus.o_Memory_Write_Enable = 1'b0;
        arb_bus.o_Memory_Write_Data   = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            if (grant_q[n]) begin
                arb_bus.o_Memory_Address      |= arb_bus.i_Address[n*memory_size_log +: memory_size_log];
                arb_bus.o_Memory_Write_Enable |= arb_bus.i_Write_Enable[n];
                arb_bus.o_Memory_Write_Data   |= arb_bus.i_Write_Data[n*data_width +: data_width];
            end
        end
    end

    assign arb_bus.o_Grant = grant_q;
    assign arb_bus.o_Busy  = |grant_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    assign arb_bus.o_Timeout = timeout_q;
`else
    assign arb_bus.o_Timeout = 1'b0;
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus queues expected grants, a negedge monitor checks them.
// Covers both builds (ARB_HOLD_TIMEOUT_EN defined or not) with MAX_HOLD = 8.
module tb_memory_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    localparam logic [AW-1:0] CU_ADDR [NR] = '{10'h011, 10'h122, 10'h233, 10'h344};
    localparam logic [DW-1:0] CU_DATA [NR] = '{32'hDEAD_0000, 32'hBEEF_1111,
                                               32'hCAFE_2222, 32'hF00D_3333};

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [NR-1:0] prev_grant;

    memory_arbiter_if #(.NUM_REQ(NR), .memory_size_log(AW), .data_width(DW)) bus ();

    memory_arbiter #(
        .NUM_REQ(NR), .REQ_LOG(2), .memory_size_log(AW), .data_width(DW), .MAX_HOLD(8)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .arb_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int n);
        exp_t e;
        e.grant = '0;
        e.grant[n] = 1'b1;
        e.addr  = CU_ADDR[n];
        e.we    = bus.i_Write_Enable[n];
        e.data  = CU_DATA[n];
        exp_q.push_back(e);
    endtask

    // Monitor: each new non-zero grant must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.o_Grant != prev_grant && bus.o_Grant != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %b, expected none", bus.o_Grant);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("grant", 64'(bus.o_Grant), 64'(e.grant));
                chk("mem_addr", 64'(bus.o_Memory_Address), 64'(e.addr));
                chk("mem_we", 64'(bus.o_Memory_Write_Enable), 64'(e.we));
                chk("mem_wdata", 64'(bus.o_Memory_Write_Data), 64'(e.data));
                chk("busy_on_grant", 64'(bus.o_Busy), 64'd1);
            end
        end
        prev_grant <= bus.o_Grant;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        prev_grant = '0;
        rst = 1'b1;
        bus.i_Request = '0;
        bus.i_Write_Enable = '0;
        for (int n = 0; n < int'(NR); n++) begin
            bus.i_Address[n*AW +: AW] = CU_ADDR[n];
            bus.i_Write_Data[n*DW +: DW] = CU_DATA[n];
        end

        // 1: reset state
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_grant", 64'(bus.o_Grant), 64'd0);
        chk("rst_busy", 64'(bus.o_Busy), 64'd0);
        chk("rst_mem_we", 64'(bus.o_Memory_Write_Enable), 64'd0);
        chk("rst_timeout", 64'(bus.o_Timeout), 64'd0);

        // 2: CU2 alone; CU0's write enable must not leak
        bus.i_Write_Enable = 4'b0001;
        bus.i_Request = 4'b0100;
        push(2);
        tick(3);
        chk("cu2_hold_grant", 64'(bus.o_Grant), 64'h4);
        rst = 1'b1;
        bus.i_Request = '0;
        tick(1);
        chk("midgrant_rst_grant", 64'(bus.o_Grant), 64'd0);
        chk("midgrant_rst_busy", 64'(bus.o_Busy), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("idle_mem_we", 64'(bus.o_Memory_Write_Enable), 64'd0);
        chk("idle_mem_addr", 64'(bus.o_Memory_Address), 64'd0);
        chk("idle_mem_wdata", 64'(bus.o_Memory_Write_Data), 64'd0);

        // 3: all request, each owner drops for one cycle after three grant cycles
        bus.i_Write_Enable = 4'b1010;
        bus.i_Request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % 4;
            push(o);
            tick(3);
            bus.i_Request[o] = 1'b0;
            tick(1);
            chk("rr_gap", 64'(bus.o_Grant), 64'd0);
            bus.i_Request[o] = 1'b1;
        end
        bus.i_Request = '0;
        tick(2);

        // 4: no preemption, then round robin after CU1 skips CU0 in favour of CU3
        bus.i_Write_Enable = 4'b0000;
        bus.i_Request = 4'b0010;
        push(1);
        tick(2);
        bus.i_Request = 4'b0011;
        tick(2);
        chk("no_preempt", 64'(bus.o_Grant), 64'h2);
        bus.i_Request = 4'b1001;
        push(3);
        tick(3);
        bus.i_Request = 4'b0001;
        push(0);
        tick(4);

        // 5: CU0 drops and re-requests at once; CU1 goes first
        bus.i_Request = 4'b0010;
        push(1);
        tick(1);
        bus.i_Request = 4'b0011;
        tick(3);
        bus.i_Request = 4'b0001;
        push(0);
        tick(3);
        bus.i_Request = '0;
        tick(2);

        // 6: CU0 requests forever with CU1 waiting
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.i_Request = 4'b0011;
        push(0);
`ifdef ARB_HOLD_TIMEOUT_EN
        push(1);
        tick(1);
        for (int i = 0; i < 8; i++) begin
            chk("hold_grant", 64'(bus.o_Grant), 64'h1);
            chk("hold_no_timeout", 64'(bus.o_Timeout), 64'd0);
            tick(1);
        end
        chk("revoke_grant", 64'(bus.o_Grant), 64'd0);
        chk("revoke_timeout", 64'(bus.o_Timeout), 64'd1);
        tick(1);
        chk("timeout_pulse_end", 64'(bus.o_Timeout), 64'd0);
        chk("after_revoke_grant", 64'(bus.o_Grant), 64'h2);
`else
        tick(1);
        for (int i = 0; i < 20; i++) begin
            chk("hold_grant", 64'(bus.o_Grant), 64'h1);
            chk("hold_no_timeout", 64'(bus.o_Timeout), 64'd0);
            tick(1);
        end
`endif
        bus.i_Request = '0;
        tick(4);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
